// File: rtl/rr_arbiter_8_if.sv
// rr_arbiter_8_if: request/grant bundle between requesters and the
// eight-way round-robin arbiter.
//   req      8  request lines, bit k = requester k
//   done     1  release strobe from the current grant holder
//   gnt_idx  3  granted requester index (decoder select)
//   gnt_en   1  grant valid (decoder enable)
//   tmo      1  one-cycle pulse after a hold-limit forced release
// master: requester side; slave: arbiter side.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic       gnt_en;
  logic       tmo;

  modport master (
    output req,
    output done,
    input  gnt_idx,
    input  gnt_en,
    input  tmo
  );

  modport slave (
    input  req,
    input  done,
    output gnt_idx,
    output gnt_en,
    output tmo
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter feeding a 3-to-8 decoder.
// A grant is held until the holder strobes done, drops its request, or
// has been granted for HOLD_MAX consecutive cycles. Priority then rotates
// to the requester after the last winner. Every release passes through
// one IDLE cycle, so gnt_en always drops between grants.
// Ports:
//   clk    1  system clock, rising edge
//   rst_n  1  synchronous active-low reset
//   bus       rr_arbiter_8_if.slave (req, done in; gnt_idx, gnt_en, tmo out)
// Parameter:
//   HOLD_MAX  maximum consecutive grant cycles, 1..255
module rr_arbiter_8 #(
  parameter int HOLD_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_arbiter_8_if.slave        bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Counter value reached in the final permitted grant cycle.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state_r;
  logic [2:0] ptr_r;
  logic [7:0] hcnt_r;
  logic [2:0] gnt_idx_r;
  logic       gnt_en_r;
  logic       tmo_r;

  logic       req_any_s;
  logic [2:0] pick_s;
  logic       rel_done_s;
  logic       rel_drop_s;
  logic       rel_hold_s;
  logic       rel_s;

  // First set request bit scanning from p upward, modulo 8. Scanning the
  // offsets from high to low lets the lowest offset overwrite the result.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] sel;
    logic [2:0] k;
    sel = p;
    for (int i = 7; i >= 0; i--) begin
      k = p + 3'(i);
      if (r[k]) begin
        sel = k;
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  // Winner selection and release-cause decode.
  always_comb begin
    req_any_s  = 1'b0;
    pick_s     = 3'd0;
    rel_done_s = 1'b0;
    rel_drop_s = 1'b0;
    rel_hold_s = 1'b0;
    rel_s      = 1'b0;

    req_any_s  = |bus.req;
    pick_s     = rr_pick(bus.req, ptr_r);
    rel_done_s = bus.done;
    rel_drop_s = ~bus.req[gnt_idx_r];
    rel_hold_s = (hcnt_r == HOLD_LAST);
    rel_s      = rel_done_s | rel_drop_s | rel_hold_s;
  end

  // Arbiter state machine with registered grant outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ptr_r     <= 3'd0;
      hcnt_r    <= 8'd0;
      gnt_idx_r <= 3'd0;
      gnt_en_r  <= 1'b0;
      tmo_r     <= 1'b0;
    end else begin
      // tmo is a pulse: cleared unless set below.
      tmo_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_any_s) begin
            gnt_idx_r <= pick_s;
            gnt_en_r  <= 1'b1;
            hcnt_r    <= 8'd0;
            state_r   <= GRANT;
          end else begin
            state_r   <= IDLE;
          end
        end
        GRANT: begin
          if (rel_s) begin
            gnt_en_r <= 1'b0;
            state_r  <= IDLE;
            ptr_r    <= gnt_idx_r + 3'd1;
            // Flag only releases caused purely by the hold limit.
            tmo_r    <= rel_hold_s & ~rel_done_s & ~rel_drop_s;
          end else begin
            hcnt_r   <= hcnt_r + 8'd1;
          end
        end
        default: begin
          state_r  <= IDLE;
          gnt_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_idx = gnt_idx_r;
  assign bus.gnt_en  = gnt_en_r;
  assign bus.tmo     = tmo_r;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed self-checking bench for rr_arbiter_8 with
// HOLD_MAX=4. Inputs change 1 time unit after a rising edge; outputs are
// checked at the same point, i.e. reflecting the edge just taken.
module tb_rr_arbiter_8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [2:0] idx);
    check({tag, "_en"},  {7'd0, bus.gnt_en}, 8'd1);
    check({tag, "_idx"}, {5'd0, bus.gnt_idx}, {5'd0, idx});
    check({tag, "_tmo"}, {7'd0, bus.tmo}, 8'd0);
  endtask

  task automatic check_idle(input string tag, input logic tmo_exp);
    check({tag, "_en"},  {7'd0, bus.gnt_en}, 8'd0);
    check({tag, "_tmo"}, {7'd0, bus.tmo}, {7'd0, tmo_exp});
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    bus.req  = 8'hFF;
    bus.done = 1'b0;

    // Reset values with all requests pending.
    step();
    step();
    check("rst_en",  {7'd0, bus.gnt_en}, 8'd0);
    check("rst_idx", {5'd0, bus.gnt_idx}, 8'd0);
    check("rst_tmo", {7'd0, bus.tmo}, 8'd0);
    rst_n = 1'b1;
    step();
    check_grant("first", 3'd0);

    // Rotation: done on every grant cycle, expect 1..7,0.
    bus.done = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_idle("rot_gap", 1'b0);
      step();
      check_grant("rot", 3'(k));
    end
    step();
    check_idle("rot_end", 1'b0);

    // Wrap/skip from ptr=0: expect 1, 7, 1, 7 then 0.
    rst_n   = 1'b0;
    bus.req = 8'h00;
    step();
    rst_n   = 1'b1;
    bus.req = 8'b1000_0010;
    step();
    check_grant("wrap_a", 3'd1);
    step();
    check_idle("wrap_a_gap", 1'b0);
    step();
    check_grant("wrap_b", 3'd7);
    step();
    step();
    check_grant("wrap_c", 3'd1);
    step();
    step();
    check_grant("wrap_d", 3'd7);
    bus.req = 8'b0000_0001;
    step();
    check_idle("wrap_drop", 1'b0);
    step();
    check_grant("wrap_e", 3'd0);
    step();
    check_idle("wrap_e_gap", 1'b0);

    // Hold limit: requester 3 alone, no done; 4 grant cycles then tmo.
    bus.done = 1'b0;
    bus.req  = 8'h08;
    step();
    check_grant("hold_c0", 3'd3);
    for (int c = 1; c < 4; c++) begin
      step();
      check_grant("hold_cn", 3'd3);
    end
    step();
    check_idle("hold_tmo", 1'b1);
    step();
    check_grant("hold_regrant", 3'd3);

    // done coincident with the hold limit: release without tmo.
    step();
    step();
    step();
    check_grant("both_last", 3'd3);
    bus.done = 1'b1;
    step();
    check_idle("both_rel", 1'b0);
    bus.done = 1'b0;
    step();
    check_grant("drop_grant", 3'd3);
    step();
    bus.req = 8'h00;
    step();
    check_idle("drop_rel", 1'b0);
    step();
    check_idle("drop_stay", 1'b0);

    // Reset mid-grant of requester 5.
    bus.req = 8'h20;
    step();
    check_grant("rstm_grant", 3'd5);
    rst_n = 1'b0;
    step();
    check_idle("rstm_rst", 1'b0);
    check("rstm_idx", {5'd0, bus.gnt_idx}, 8'd0);
    rst_n = 1'b1;
    step();
    check_grant("rstm_regrant", 3'd5);

    // Pointer reset: from ptr=6 requester 6 would win; after reset, 0 wins.
    bus.done = 1'b1;
    step();
    check_idle("ptr_rel", 1'b0);
    bus.done = 1'b0;
    bus.req  = 8'h41;
    step();
    check_grant("ptr_pre", 3'd6);
    rst_n = 1'b0;
    step();
    check_idle("ptr_rst", 1'b0);
    rst_n = 1'b1;
    step();
    check_grant("ptr_post", 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-way round-robin arbiter that sits directly upstream of the 3-to-8 decoder. It takes eight request lines and produces a registered 3-bit grant index plus a grant-enable. When those drive the decoder's select and enable, the decoder output is a one-hot grant vector. Grants are held until the requester releases, drops its request, or exceeds a hold limit. Priority then rotates past the last winner.

## Interface
- `HOLD_MAX`, default 15: maximum number of consecutive cycles one grant may stay asserted. Legal range is 1..255.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous reset, active-low; sampled on the rising edge of `clk`.
- `req`  input  8  request lines; bit k = requester k.
- `done`  input  1  release strobe from the current grant holder; ignored while no grant is active.
- `gnt_idx`  output  3  index of the granted requester; drives decoder select.
- `gnt_en`  output  1  grant valid; drives decoder enable.
- `tmo`  output  1  one-cycle pulse, high in the first cycle after a grant is force-released by the hold limit.

## Operation
- **Reset** (`rst_n`=0 at a rising edge):
  - State goes to IDLE.
  - `gnt_idx`=0, `gnt_en`=0, `tmo`=0.
  - Rotation pointer `ptr`=0 and hold counter `hcnt`=0.
  - Reset mid-grant drops `gnt_en` on that same edge; no release bookkeeping is performed.
- **State machine**, two states:
  - **IDLE**:
    - If `req`≠0, select the first set bit scanning `ptr`, `ptr`+1, … , `ptr`+7, with indices taken modulo 8.
    - Load that index into `gnt_idx`, set `gnt_en`=1, clear `hcnt`, and go to GRANT.
    - If `req`=0, stay in IDLE; `gnt_idx` holds its last value.
  - **GRANT**: evaluated every cycle. Release occurs if any of the following holds:
    - (a) `done`=1;
    - (b) `req[gnt_idx]`=0;
    - (c) `hcnt`=`HOLD_MAX`-1.
  - **On release**:
    - `gnt_en`←0 and state goes to IDLE.
    - `ptr`←`gnt_idx`+1 (3-bit wrap, so 7→0).
    - `tmo`←1 only if (c) is the sole cause; if (a) or (b) is also true, `tmo` stays 0.
  - **Otherwise**: `hcnt`←`hcnt`+1 and stay in GRANT.
- `hcnt` width is 8 bits, sufficient for `HOLD_MAX`≤255. It never wraps, because release occurs at `HOLD_MAX`-1.
- **Every release passes through one IDLE cycle.** `gnt_en` is therefore low for at least one cycle between consecutive grants, including back-to-back grants to different requesters. Downstream sees the decoder output go to all-zero between grants.
- `gnt_idx` changes only on the edge that enters GRANT. It is stable for the whole period `gnt_en`=1.
- **`tmo` is a pulse.** It is cleared on every edge where it is not being set.
- Requests that rise or fall while another requester holds the grant have no effect until the next IDLE evaluation.
- A requester that has been released may re-win immediately only if no other requester is set, because `ptr` has advanced past it.

## Timing
- **Grant latency:** `req` sampled non-zero in IDLE at edge N gives `gnt_en`=1 and a valid `gnt_idx` after edge N. The decoder output is valid in the same cycle (combinational).
- **Release latency:** `done` or a `req` drop sampled at edge M gives `gnt_en`=0 after edge M.
- **Hold limit:** with `req[gnt_idx]` held high and `done`=0, `gnt_en` is high for exactly `HOLD_MAX` cycles. `tmo` is high in the following cycle, coincident with `gnt_en`=0.
- `HOLD_MAX`=1 gives a single-cycle grant with `tmo` on every grant where `done`=0.
- **Minimum grant period** is 2 cycles: 1 cycle granted plus 1 cycle IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset values:** assert `rst_n`=0 for 2 cycles with `req`=8'hFF. Expect `gnt_en`=0, `gnt_idx`=0 and `tmo`=0. On release with `req`=8'hFF, the first grant is `gnt_idx`=0 one cycle later.
- **Rotation:** `req`=8'hFF held, `done` pulsed on every grant cycle. Expect `gnt_idx` sequence 0,1,2,…,7,0 with `gnt_en` alternating 1,0,1,0, and `tmo` never set.
- **Wrap / skip:** `req`=8'b1000_0010, starting with `ptr`=0. Expect grant 1, then 7, then 1. Then set `req`=8'b0000_0001 after the grant to 7; expect the next grant to be 0.
- **Hold limit:** `HOLD_MAX`=4, `req`=8'h08 held, `done`=0. Expect `gnt_idx`=3 and `gnt_en` high for 4 cycles, then low with `tmo`=1 for 1 cycle. Expect regrant to 3 the cycle after that.
- **Simultaneous causes:** in the final hold cycle, assert `done`=1 together with the timeout. Expect release and `tmo`=0. Separately, drop `req[gnt_idx]` mid-grant and expect `gnt_en`=0 on the next edge.
- **Reset mid-grant:** during an active grant of `gnt_idx`=5, pulse `rst_n`=0 for 1 cycle with `req`=8'h20. Expect `gnt_en`=0 for one cycle, then regrant to 5 with `ptr` having been reset to 0.
